// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
// Scans a 4x4 active-low keypad matrix, debounces whole-frame results and
// turns every physical key press into exactly one single-cycle button code
// for the calculator core. A one-entry pending register holds the code while
// the core is busy. A code accepted while that register is still occupied is
// dropped, and overrun_o pulses.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   row_n_i     in   [3:0] row sense, active-low, asynchronous to clk
//   col_n_o     out  [3:0] column drive, active-low one-hot
//   busy_i      in   calculator not ready; pending code is held
//   button_o    out  [7:0] {2'b00, col[1:0], 2'b01, row[1:0]} for one cycle, else 8'h00
//   key_valid_o out  high in the same cycle button_o is non-zero
//   overrun_o   out  one-cycle pulse when an accepted code is dropped
//
// Handshake: the core takes button_o in any cycle where key_valid_o is high.
// The block only presents a code in a cycle following one where busy_i was
// low, so there is no ready/accept return path beyond busy_i.
module keypad_scan_ctrl #(
  parameter int unsigned SCAN_DIV        = 4,
  parameter int unsigned DEBOUNCE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n_i,
  output logic [3:0] col_n_o,
  input  logic       busy_i,
  output logic [7:0] button_o,
  output logic       key_valid_o,
  output logic       overrun_o
);

  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [4:0]    DEB_MAX    = 5'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEB  = 2'd1,
    ST_HELD = 2'd2,
    ST_REL  = 2'd3
  } state_e;

  // Row synchronizer
  logic [3:0] row_s1_q, row_s2_q;

  // Scan counters
  logic [DW-1:0] dwell_q;
  logic [1:0]    col_idx_q;

  // Frame accumulator: key count saturates at 2 (= two or more)
  logic [1:0] acc_keys_q;
  logic [1:0] acc_c_q, acc_r_q;

  // Debounce FSM
  state_e     state_q;
  logic [1:0] cand_c_q, cand_r_q;
  logic [3:0] cnt_q;

  // Output path
  logic       pend_full_q;
  logic [7:0] pend_q;
  logic [7:0] button_q;
  logic       key_valid_q;
  logic       overrun_q;

  assign col_n_o     = ~(4'b0001 << col_idx_q);
  assign button_o    = button_q;
  assign key_valid_o = key_valid_q;
  assign overrun_o   = overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1_q <= 4'b1111;
      row_s2_q <= 4'b1111;
    end else begin
      row_s1_q <= row_n_i;
      row_s2_q <= row_s1_q;
    end
  end

  logic sample, frame_eval;
  assign sample     = (dwell_q == DWELL_LAST);
  assign frame_eval = sample && (col_idx_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q   <= '0;
      col_idx_q <= 2'd0;
    end else if (sample) begin
      dwell_q   <= '0;
      col_idx_q <= col_idx_q + 2'd1;
    end else begin
      dwell_q   <= dwell_q + 1'b1;
    end
  end

  // Keys active in the currently driven column (count saturates at 2)
  logic [3:0] act;
  logic [1:0] col_keys;
  logic [1:0] col_row;
  assign act = ~row_s2_q;

  always_comb begin
    col_keys = 2'd0;
    col_row  = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (act[k]) begin
        if (col_keys == 2'd0) col_row = 2'(k);
        if (col_keys != 2'd2) col_keys = col_keys + 2'd1;
      end
    end
  end

  // Running frame totals including the current column. Column 0 restarts
  // the accumulation, so no separate clear is needed.
  logic [2:0] sum_keys;
  logic [1:0] tot_keys;
  logic [1:0] frm_c, frm_r;

  always_comb begin
    sum_keys = {1'b0, col_keys} + ((col_idx_q == 2'd0) ? 3'd0 : {1'b0, acc_keys_q});
    tot_keys = (sum_keys >= 3'd2) ? 2'd2 : sum_keys[1:0];
    if (col_keys != 2'd0 || col_idx_q == 2'd0) begin
      frm_c = col_idx_q;
      frm_r = col_row;
    end else begin
      frm_c = acc_c_q;
      frm_r = acc_r_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_keys_q <= 2'd0;
      acc_c_q    <= 2'd0;
      acc_r_q    <= 2'd0;
    end else if (sample) begin
      acc_keys_q <= tot_keys;
      acc_c_q    <= frm_c;
      acc_r_q    <= frm_r;
    end
  end

  logic frm_none, frm_single, same_cand, cnt_done, accept;
  logic [7:0] frm_code;
  assign frm_none   = frame_eval && (tot_keys == 2'd0);
  assign frm_single = frame_eval && (tot_keys == 2'd1);
  assign same_cand  = (frm_c == cand_c_q) && (frm_r == cand_r_q);
  assign cnt_done   = (({1'b0, cnt_q} + 5'd1) >= DEB_MAX);
  assign frm_code   = {2'b00, frm_c, 2'b01, frm_r};

  // Acceptance is decided combinationally so the code lands in the pending
  // register on the same edge the FSM enters HELD.
  assign accept = frm_single &&
                  (((state_q == ST_IDLE) && (DEB_MAX <= 5'd1)) ||
                   ((state_q == ST_DEB) && same_cand && cnt_done));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cand_c_q <= 2'd0;
      cand_r_q <= 2'd0;
      cnt_q    <= 4'd0;
    end else if (frame_eval) begin
      case (state_q)
        ST_IDLE: begin
          if (frm_single) begin
            cand_c_q <= frm_c;
            cand_r_q <= frm_r;
            cnt_q    <= 4'd1;
            state_q  <= accept ? ST_HELD : ST_DEB;
          end
        end
        ST_DEB: begin
          if (frm_single) begin
            if (same_cand) begin
              if (cnt_done) begin
                cnt_q   <= DEB_MAX[3:0];
                state_q <= ST_HELD;
              end else begin
                cnt_q <= cnt_q + 4'd1;
              end
            end else begin
              cand_c_q <= frm_c;
              cand_r_q <= frm_r;
              cnt_q    <= 4'd1;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_HELD: begin
          if (frm_none) begin
            cnt_q   <= 4'd1;
            state_q <= (DEB_MAX <= 5'd1) ? ST_IDLE : ST_REL;
          end
        end
        ST_REL: begin
          if (frm_none) begin
            if (cnt_done) begin
              cnt_q   <= DEB_MAX[3:0];
              state_q <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end else begin
            state_q <= ST_HELD;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Pending register and registered output stage
  logic issue;
  assign issue = pend_full_q && !busy_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full_q <= 1'b0;
      pend_q      <= 8'h00;
      button_q    <= 8'h00;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      button_q    <= issue ? pend_q : 8'h00;
      key_valid_q <= issue;
      overrun_q   <= accept && pend_full_q && !issue;
      if (accept) begin
        // Refill is allowed when the old code leaves this very cycle
        if (!pend_full_q || issue) begin
          pend_q      <= frm_code;
          pend_full_q <= 1'b1;
        end
      end else if (issue) begin
        pend_full_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Testbench for keypad_scan_ctrl: behavioural keypad matrix, scoreboard of
// expected button codes, cycle-accurate latency check, busy/overrun and
// mid-operation reset scenarios.
module tb_keypad_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic       busy;
  logic [7:0] button;
  logic       key_valid;
  logic       overrun;

  // Pressed keys, bit index = col*4 + row
  logic [15:0] keys;

  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned cyc;
  int unsigned out_cnt;
  int unsigned ovr_cnt;
  int unsigned last_out_cyc;
  logic [7:0]  exp_q[$];

  keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .row_n_i    (row_n),
    .col_n_o    (col_n),
    .busy_i     (busy),
    .button_o   (button),
    .key_valid_o(key_valid),
    .overrun_o  (overrun)
  );

  // Clock / reset-relative cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Keypad matrix model: a pressed key pulls its row low while its column is driven
  always_comb begin
    row_n = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col_n[c] && keys[c*4+r]) row_n[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (overrun) ovr_cnt++;
      if (key_valid || button != 8'h00) begin
        out_cnt++;
        last_out_cyc = cyc;
        check("valid_with_code", {31'd0, key_valid}, 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_code", {24'd0, button}, 32'd0);
        end else begin
          check("button_code", {24'd0, button}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // Driver tasks
  task automatic wait_eval(output int unsigned e);
    bit found;
    found = 0;
    e = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if ((cyc % 16) == 15) begin
        found = 1;
        e = cyc;
      end
    end
    if (!found) check("frame_align_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_frames(input int n);
    repeat (n * 16) @(negedge clk);
  endtask

  task automatic set_key(input int c, input int r, input logic v);
    keys[c*4+r] = v;
  endtask

  task automatic press(input int c, input int r, input int hold, input int rel);
    int unsigned e;
    wait_eval(e);
    set_key(c, r, 1'b1);
    wait_frames(hold);
    set_key(c, r, 1'b0);
    wait_frames(rel);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_col_n", {28'd0, col_n}, 32'hE);
    check("rst_button", {24'd0, button}, 32'd0);
    check("rst_key_valid", {31'd0, key_valid}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int unsigned e;
    int unsigned base_out;
    n_checks = 0; n_errors = 0; out_cnt = 0; ovr_cnt = 0; last_out_cyc = 0;
    rst_n = 1'b0; busy = 1'b0; keys = 16'h0;
    do_reset();

    // 1: column rotation with no keys
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("col_rotate", {28'd0, col_n}, {28'd0, ~(4'b0001 << ((cyc / 4) % 4))});
    end
    check("idle_no_output", out_cnt, 0);

    // 2: single press of five, with exact latency
    base_out = out_cnt;
    exp_q.push_back(8'h16);
    wait_eval(e);
    set_key(1, 2, 1'b1);
    wait_frames(6);
    set_key(1, 2, 1'b0);
    wait_frames(4);
    check("five_once", out_cnt - base_out, 1);
    check("five_latency", last_out_cyc, e + 50);

    // 3: five, add, three, equal
    base_out = out_cnt;
    exp_q.push_back(8'h16); press(1, 2, 5, 4);
    exp_q.push_back(8'h37); press(3, 3, 5, 4);
    exp_q.push_back(8'h25); press(2, 1, 5, 4);
    exp_q.push_back(8'h24); press(2, 0, 5, 4);
    check("seq_count", out_cnt - base_out, 4);

    // 4a: bounce then stable
    base_out = out_cnt;
    exp_q.push_back(8'h16);
    wait_eval(e);
    for (int i = 0; i < 5; i++) begin
      set_key(1, 2, (i % 2) == 0);
      repeat (10) @(negedge clk);
    end
    set_key(1, 2, 1'b1);
    wait_frames(4);
    set_key(1, 2, 1'b0);
    wait_frames(4);
    check("bounce_once", out_cnt - base_out, 1);

    // 4b: too-short press
    base_out = out_cnt;
    press(1, 2, 2, 4);
    check("short_press_none", out_cnt - base_out, 0);

    // 5: ghost rejection, then the remaining key is accepted
    base_out = out_cnt;
    wait_eval(e);
    set_key(2, 1, 1'b1);
    set_key(3, 2, 1'b1);
    wait_frames(5);
    check("multi_none", out_cnt - base_out, 0);
    exp_q.push_back(8'h25);
    set_key(3, 2, 1'b0);
    wait_frames(5);
    set_key(2, 1, 1'b0);
    wait_frames(4);
    check("multi_then_single", out_cnt - base_out, 1);

    // 6: busy stall with overrun
    base_out = out_cnt;
    @(negedge clk);
    busy = 1'b1;
    press(2, 1, 5, 4);
    press(2, 0, 5, 4);
    check("busy_no_output", out_cnt - base_out, 0);
    check("overrun_once", ovr_cnt, 1);
    exp_q.push_back(8'h25);
    busy = 1'b0;
    wait_frames(2);
    check("busy_release_out", out_cnt - base_out, 1);

    // Mid-operation reset: pending code lost, held key emitted once afterwards
    base_out = out_cnt;
    @(negedge clk);
    busy = 1'b1;
    wait_eval(e);
    set_key(0, 0, 1'b1);
    wait_frames(4);
    do_reset();
    busy = 1'b0;
    exp_q.push_back(8'h04);
    wait_frames(5);
    set_key(0, 0, 1'b0);
    wait_frames(4);
    check("reset_reemit_once", out_cnt - base_out, 1);
    check("overrun_total", ovr_cnt, 1);

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
